decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised successor to the single-register decode stage, sitting between fetch and execute. It buffers fetched instructions in a DEPTH-entry queue that tags each entry with its PC. It decodes the queue head into a registered execute-stage bundle under full valid/ready back-pressure. It raises a precise, sticky trap for illegal opcodes and, optionally, for ECALL/EBREAK. The register file stays outside this block; the rs*_addr/sel outputs feed it.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥2.
- SUPPORT_SYSTEM, 1: 1 = ECALL/EBREAK raise traps; 0 = decoded as NOP.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_reset_i  in  32  PC tagged on first fetched instruction after reset; sampled while rst=1.
- jump_i  in  1  redirect: flush queue, output register and trap lock.
- pc_jump_i  in  32  new PC when jump_i=1.
- fetch_valid_i  in  1  fetch beat valid.
- fetch_ready_o  out  1  queue not full.
- fetch_instr_i  in  32  raw RV32I instruction.
- id_valid_o  out  1  output bundle valid.
- id_ready_i  in  1  execute accepts bundle.
- id_pc_o  out  32  PC of bundle.
- rd_addr_o, rs1_addr_o, rs2_addr_o  out  5 each  register fields.
- rs1_sel_o, rs2_sel_o  out  1 each  operand comes from register file.
- imm_o  out  32  sign-extended immediate.
- f3_o  out  3;  f7_o  out  1 (instr[30] for OP/OP-IMM shifts).
- we_rd_o  out  1  writeback enable.
- lsu_o  out  2  0 none, 1 load, 2 store.
- branch_o, jump_o  out  1 each.
- trap_o  out  1  bundle carries a trap.
- trap_cause_o  out  4  2 illegal, 3 EBREAK, 11 ECALL.

## Operation
- Enqueue on fetch_valid_i && fetch_ready_o && !jump_i. Entry = {instr, pc_cnt}; then pc_cnt += 4, mod 2^32.
- fetch_ready_o = (count != DEPTH), taken from registered count only; independent of id_ready_i. No push while full, even if a pop happens in the same cycle.
- Output register loads the decoded head when the queue is non-empty, !lock, and (!id_valid_o || id_ready_i). Otherwise id_valid_o clears on handshake, or holds the bundle unchanged while id_ready_i=0.
- Opcode decode (instr[6:0]):
  - OP-IMM: I-imm, we_rd, rs1_sel.
  - LUI / AUIPC: U-imm, we_rd, rs1_sel=0.
  - OP: rs1_sel, rs2_sel, we_rd.
  - JAL: J-imm, jump, we_rd.
  - JALR: I-imm, jump, we_rd, rs1_sel.
  - BRANCH: B-imm, branch, rs1_sel, rs2_sel.
  - LOAD: I-imm, lsu=1, we_rd, rs1_sel.
  - STORE: S-imm, lsu=2, rs1_sel, rs2_sel.
  - MISC-MEM: NOP.
  - SYSTEM: 0x00000073 is ECALL and 0x00100073 is EBREAK when SUPPORT_SYSTEM=1; everything else is NOP.
  - Any other opcode: illegal.
- Trapping bundle: trap_o=1, we_rd/lsu/branch/jump = 0, id_pc_o = faulting PC. Loading it sets lock. While lock=1 the queue is not popped, but fetch may still fill it.
- jump_i (priority over everything except rst), same edge:
  - count ← 0, id_valid_o ← 0, lock ← 0, pc_cnt ← pc_jump_i.
  - A concurrent fetch beat is dropped. A concurrent id handshake is still considered completed.
- Reset values: count=0, lock=0, pc_cnt=pc_reset_i, id_valid_o=0, all bundle outputs 0, trap_o=0, fetch_ready_o=1 the cycle after reset.

## Timing
- Latency: beat accepted at edge N → id_valid_o at edge N+1 when the queue was empty and the output register was free. Decode is combinational from the head and registered into the output register.
- Throughput: 1 instruction/cycle sustained with id_ready_i=1.
- Bundle outputs are stable while id_valid_o && !id_ready_i.
- A trap bundle is presented once. No further bundles are presented until jump_i.
- rst mid-operation discards all queue contents and lock at the next edge.
- pc_cnt wraps from 0xFFFFFFFC to 0x00000000 silently.

## Test plan
- Reset pc_reset_i=0x80000000, stream ADDI x1,x0,5 (0x00500093) ×3 with id_ready_i=1 → three bundles, id_pc_o 0x80000000/04/08, imm_o=5, rd_addr_o=1, we_rd_o=1, back-to-back cycles.
- DEPTH=4, id_ready_i=0, push 6 beats → fetch_ready_o low after 4 accepted (plus 1 held in output). Release → all 5 drain in order and the 6th beat is accepted once fetch_ready_o rises.
- Feed 0xFFFFFFFF at PC 0x100 → trap_o=1, trap_cause_o=2, id_pc_o=0x100, we_rd_o=0. Later instructions stay queued. jump_i with pc_jump_i=0x200 → lock cleared, queue empty, next instruction tagged 0x200.
- ECALL (0x00000073) with SUPPORT_SYSTEM=1 → trap_cause_o=11. With SUPPORT_SYSTEM=0 → NOP bundle, trap_o=0.
- jump_i asserted in the same cycle as fetch_valid_i and a pending output → beat dropped, id_valid_o=0 next cycle, count=0.
- BEQ with imm -4 (0xFE000EE3) → imm_o=0xFFFFFFFC, branch_o=1, rs1_sel_o=rs2_sel_o=1, we_rd_o=0.

Source files
------------

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshakes of decode_queue.
// The DUT takes the slave modport; the producer/consumer takes master.
interface decode_queue_if;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_instr_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [4:0]  rd_addr_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic        rs1_sel_o;
  logic        rs2_sel_o;
  logic [31:0] imm_o;
  logic [2:0]  f3_o;
  logic        f7_o;
  logic        we_rd_o;
  logic [1:0]  lsu_o;
  logic        branch_o;
  logic        jump_o;
  logic        trap_o;
  logic [3:0]  trap_cause_o;

  modport slave (
    input  fetch_valid_i, fetch_instr_i, id_ready_i,
    output fetch_ready_o, id_valid_o, id_pc_o,
    output rd_addr_o, rs1_addr_o, rs2_addr_o,
    output rs1_sel_o, rs2_sel_o, imm_o, f3_o, f7_o,
    output we_rd_o, lsu_o, branch_o, jump_o,
    output trap_o, trap_cause_o
  );

  modport master (
    output fetch_valid_i, fetch_instr_i, id_ready_i,
    input  fetch_ready_o, id_valid_o, id_pc_o,
    input  rd_addr_o, rs1_addr_o, rs2_addr_o,
    input  rs1_sel_o, rs2_sel_o, imm_o, f3_o, f7_o,
    input  we_rd_o, lsu_o, branch_o, jump_o,
    input  trap_o, trap_cause_o
  );
endinterface

// File: rtl/decode_queue.sv
// PC-tagged instruction queue feeding a registered RV32I decode bundle.
// Traps are precise and sticky until the next redirect.
module decode_queue #(
  parameter int DEPTH          = 4,
  parameter bit SUPPORT_SYSTEM = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc_reset_i,
  input  logic          jump_i,
  input  logic [31:0]   pc_jump_i,
  decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_MISC   = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_sel;
    logic        rs2_sel;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7;
    logic        we_rd;
    logic [1:0]  lsu;
    logic        branch;
    logic        jump;
    logic        trap;
    logic [3:0]  cause;
  } bundle_t;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc_cnt;
  logic          lock;
  logic          valid_q;
  logic [31:0]   pc_out;
  bundle_t       dec;
  bundle_t       out_q;
  logic          push;
  logic          pop;
  logic [31:0]   ins;
  logic [6:0]    opc;
  logic [31:0]   imm_i;
  logic [31:0]   imm_s;
  logic [31:0]   imm_b;
  logic [31:0]   imm_u;
  logic [31:0]   imm_j;

  assign q.fetch_ready_o = count != (AW+1)'(DEPTH);

  assign push = q.fetch_valid_i && q.fetch_ready_o
              && !jump_i && !rst;
  assign pop  = (count != '0) && !lock
              && (!valid_q || q.id_ready_i);

  assign ins = instr_q[rd_ptr];
  assign opc = ins[6:0];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'h000};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    dec.rd  = ins[11:7];
    dec.rs1 = ins[19:15];
    dec.rs2 = ins[24:20];
    dec.f3  = ins[14:12];
    dec.f7  = ins[30];
    unique case (1'b1)
      opc == OPC_OPIMM: begin
        dec.imm     = imm_i;
        dec.we_rd   = 1'b1;
        dec.rs1_sel = 1'b1;
      end
      opc == OPC_LUI,
      opc == OPC_AUIPC: begin
        dec.imm   = imm_u;
        dec.we_rd = 1'b1;
      end
      opc == OPC_OP: begin
        dec.rs1_sel = 1'b1;
        dec.rs2_sel = 1'b1;
        dec.we_rd   = 1'b1;
      end
      opc == OPC_JAL: begin
        dec.imm   = imm_j;
        dec.jump  = 1'b1;
        dec.we_rd = 1'b1;
      end
      opc == OPC_JALR: begin
        dec.imm     = imm_i;
        dec.jump    = 1'b1;
        dec.we_rd   = 1'b1;
        dec.rs1_sel = 1'b1;
      end
      opc == OPC_BRANCH: begin
        dec.imm     = imm_b;
        dec.branch  = 1'b1;
        dec.rs1_sel = 1'b1;
        dec.rs2_sel = 1'b1;
      end
      opc == OPC_LOAD: begin
        dec.imm     = imm_i;
        dec.lsu     = 2'd1;
        dec.we_rd   = 1'b1;
        dec.rs1_sel = 1'b1;
      end
      opc == OPC_STORE: begin
        dec.imm     = imm_s;
        dec.lsu     = 2'd2;
        dec.rs1_sel = 1'b1;
        dec.rs2_sel = 1'b1;
      end
      opc == OPC_MISC: begin
      end
      opc == OPC_SYSTEM: begin
        // CSR and other SYSTEM forms fall through as NOPs
        if (SUPPORT_SYSTEM && ins == 32'h0000_0073) begin
          dec.trap  = 1'b1;
          dec.cause = 4'd11;
        end else if (SUPPORT_SYSTEM && ins == 32'h0010_0073) begin
          dec.trap  = 1'b1;
          dec.cause = 4'd3;
        end
      end
      default: begin
        dec.trap  = 1'b1;
        dec.cause = 4'd2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= q.fetch_instr_i;
      pc_q[wr_ptr]    <= pc_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pc_cnt  <= pc_reset_i;
      lock    <= 1'b0;
      valid_q <= 1'b0;
      pc_out  <= '0;
      out_q   <= '0;
    end else if (jump_i) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pc_cnt  <= pc_jump_i;
      lock    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        pc_cnt <= pc_cnt + 32'd4;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        out_q   <= dec;
        pc_out  <= pc_q[rd_ptr];
        valid_q <= 1'b1;
        lock    <= dec.trap;
      end else if (q.id_ready_i) begin
        valid_q <= 1'b0;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign q.id_valid_o   = valid_q;
  assign q.id_pc_o      = pc_out;
  assign q.rd_addr_o    = out_q.rd;
  assign q.rs1_addr_o   = out_q.rs1;
  assign q.rs2_addr_o   = out_q.rs2;
  assign q.rs1_sel_o    = out_q.rs1_sel;
  assign q.rs2_sel_o    = out_q.rs2_sel;
  assign q.imm_o        = out_q.imm;
  assign q.f3_o         = out_q.f3;
  assign q.f7_o         = out_q.f7;
  assign q.we_rd_o      = out_q.we_rd;
  assign q.lsu_o        = out_q.lsu;
  assign q.branch_o     = out_q.branch;
  assign q.jump_o       = out_q.jump;
  assign q.trap_o       = out_q.trap;
  assign q.trap_cause_o = out_q.cause;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: decode vector table, handshake corner
// sequences and a random run against a queue-based reference model.
module tb_decode_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        jump_i;
  logic [31:0] pc_reset_i;
  logic [31:0] pc_jump_i;

  always #5 clk = ~clk;

  decode_queue_if if0 ();
  decode_queue_if if1 ();

  decode_queue #(.DEPTH(4), .SUPPORT_SYSTEM(1'b1)) dut0 (
    .clk(clk), .rst(rst), .pc_reset_i(pc_reset_i),
    .jump_i(jump_i), .pc_jump_i(pc_jump_i), .q(if0.slave)
  );

  decode_queue #(.DEPTH(4), .SUPPORT_SYSTEM(1'b0)) dut1 (
    .clk(clk), .rst(rst), .pc_reset_i(pc_reset_i),
    .jump_i(jump_i), .pc_jump_i(pc_jump_i), .q(if1.slave)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        s1;
    logic        s2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7;
    logic        we;
    logic [1:0]  lsu;
    logic        br;
    logic        jmp;
    logic        trap;
    logic [3:0]  cause;
  } bnd_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        f7;
    logic        we;
    logic [1:0]  lsu;
    logic        br;
    logic        jmp;
    logic        s1;
    logic        s2;
    logic        trap;
    logic [3:0]  cause;
  } vec_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  localparam int NV = 15;
  localparam logic [31:0] ADDI5 = 32'h0050_0093;

  vec_t  vt [NV];
  ent_t  mq [$];
  logic [31:0] m_pc;
  logic  m_valid;
  logic  m_lock;
  bnd_t  m_b;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sx_i(input logic [31:0] w);
    return 32'(int'(w[30:20]) - (w[31] ? 2048 : 0));
  endfunction

  function automatic logic [31:0] sx_s(input logic [31:0] w);
    return 32'(int'(w[11:7]) + int'(w[30:25]) * 32
               - (w[31] ? 2048 : 0));
  endfunction

  function automatic logic [31:0] sx_b(input logic [31:0] w);
    return 32'(int'(w[11:8]) * 2 + int'(w[30:25]) * 32
               + (w[7] ? 2048 : 0) - (w[31] ? 4096 : 0));
  endfunction

  function automatic logic [31:0] sx_j(input logic [31:0] w);
    return 32'(int'(w[30:21]) * 2 + (w[20] ? 2048 : 0)
               + int'(w[19:12]) * 4096
               - (w[31] ? 1048576 : 0));
  endfunction

  function automatic bnd_t ref_dec(input logic [31:0] w,
                                   input logic [31:0] pc);
    bnd_t b;
    b     = '0;
    b.pc  = pc;
    b.rd  = w[11:7];
    b.rs1 = w[19:15];
    b.rs2 = w[24:20];
    b.f3  = w[14:12];
    b.f7  = w[30];
    case (w[6:0])
      7'h13: begin b.imm = sx_i(w); b.we = 1; b.s1 = 1; end
      7'h37, 7'h17: begin b.imm = w & 32'hFFFF_F000; b.we = 1; end
      7'h33: begin b.we = 1; b.s1 = 1; b.s2 = 1; end
      7'h6f: begin b.imm = sx_j(w); b.jmp = 1; b.we = 1; end
      7'h67: begin
        b.imm = sx_i(w); b.jmp = 1; b.we = 1; b.s1 = 1;
      end
      7'h63: begin
        b.imm = sx_b(w); b.br = 1; b.s1 = 1; b.s2 = 1;
      end
      7'h03: begin
        b.imm = sx_i(w); b.lsu = 1; b.we = 1; b.s1 = 1;
      end
      7'h23: begin
        b.imm = sx_s(w); b.lsu = 2; b.s1 = 1; b.s2 = 1;
      end
      7'h0f: ;
      7'h73: begin
        if (w == 32'h0000_0073) begin b.trap = 1; b.cause = 11; end
        if (w == 32'h0010_0073) begin b.trap = 1; b.cause = 3; end
      end
      default: begin b.trap = 1; b.cause = 2; end
    endcase
    return b;
  endfunction

  task automatic model_step();
    bit push;
    bit load;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_pc    = pc_reset_i;
      m_valid = 0;
      m_lock  = 0;
      m_b     = '0;
    end else if (jump_i) begin
      mq.delete();
      m_pc    = pc_jump_i;
      m_valid = 0;
      m_lock  = 0;
    end else begin
      push = if0.fetch_valid_i && (mq.size() < 4);
      load = (mq.size() > 0) && !m_lock
           && (!m_valid || if0.id_ready_i);
      if (load) begin
        e = mq.pop_front();
        m_b = ref_dec(e.ins, e.pc);
        m_valid = 1;
        m_lock = m_b.trap;
      end else if (if0.id_ready_i) begin
        m_valid = 0;
      end
      if (push) begin
        mq.push_back('{ins: if0.fetch_instr_i, pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare();
    chk("fetch_ready", 32'(if0.fetch_ready_o),
        32'(mq.size() != 4));
    chk("id_valid", 32'(if0.id_valid_o), 32'(m_valid));
    if (m_valid) begin
      chk("pc", if0.id_pc_o, m_b.pc);
      chk("rd", 32'(if0.rd_addr_o), 32'(m_b.rd));
      chk("rs1", 32'(if0.rs1_addr_o), 32'(m_b.rs1));
      chk("rs2", 32'(if0.rs2_addr_o), 32'(m_b.rs2));
      chk("rs1_sel", 32'(if0.rs1_sel_o), 32'(m_b.s1));
      chk("rs2_sel", 32'(if0.rs2_sel_o), 32'(m_b.s2));
      chk("imm", if0.imm_o, m_b.imm);
      chk("f3", 32'(if0.f3_o), 32'(m_b.f3));
      chk("f7", 32'(if0.f7_o), 32'(m_b.f7));
      chk("we_rd", 32'(if0.we_rd_o), 32'(m_b.we));
      chk("lsu", 32'(if0.lsu_o), 32'(m_b.lsu));
      chk("branch", 32'(if0.branch_o), 32'(m_b.br));
      chk("jump", 32'(if0.jump_o), 32'(m_b.jmp));
      chk("trap", 32'(if0.trap_o), 32'(m_b.trap));
      chk("cause", 32'(if0.trap_cause_o), 32'(m_b.cause));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic redirect(input logic [31:0] pc);
    jump_i = 1; pc_jump_i = pc;
    cycle();
    jump_i = 0;
  endtask

  initial begin
    int acc;
    int seen;
    bit will;
    int r;

    vt[0]  = '{32'h0050_0093, 32'd5,         5'd1,  1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vt[1]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 5'd29, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    vt[2]  = '{32'h1234_52B7, 32'h1234_5000, 5'd5,  1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[3]  = '{32'hFFFF_F197, 32'hFFFF_F000, 5'd3,  1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[4]  = '{32'h0020_81B3, 32'd0,         5'd3,  1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    vt[5]  = '{32'h0080_00EF, 32'd8,         5'd1,  1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[6]  = '{32'h0041_00E7, 32'd4,         5'd1,  1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    vt[7]  = '{32'hFF81_2283, 32'hFFFF_FFF8, 5'd5,  1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vt[8]  = '{32'h0051_2623, 32'd12,        5'd12, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    vt[9]  = '{32'h0000_000F, 32'd0,         5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[10] = '{32'hFFFF_FFFF, 32'd0,         5'd31, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2};
    vt[11] = '{32'h0000_0073, 32'd0,         5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11};
    vt[12] = '{32'h0010_0073, 32'd0,         5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3};
    vt[13] = '{32'h3052_9073, 32'd0,         5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[14] = '{32'h4030_D093, 32'h0000_0403, 5'd1,  1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};

    rst = 1; jump_i = 0;
    pc_reset_i = 32'h8000_0000; pc_jump_i = 0;
    if0.fetch_valid_i = 0; if0.fetch_instr_i = 0;
    if0.id_ready_i = 1;
    if1.fetch_valid_i = 0; if1.fetch_instr_i = 0;
    if1.id_ready_i = 1;
    m_pc = 0; m_valid = 0; m_lock = 0; m_b = '0;

    @(negedge clk);
    cycle();
    cycle();
    chk("rst_trap", 32'(if0.trap_o), 32'd0);
    chk("rst_pc", if0.id_pc_o, 32'd0);
    chk("rst_imm", if0.imm_o, 32'd0);
    chk("rst_we", 32'(if0.we_rd_o), 32'd0);
    rst = 0;

    // three back-to-back ADDIs
    if0.fetch_valid_i = 1; if0.fetch_instr_i = ADDI5;
    cycle();
    chk("str_lat", 32'(if0.id_valid_o), 32'd0);
    cycle();
    chk("str_v0", 32'(if0.id_valid_o), 32'd1);
    chk("str_pc0", if0.id_pc_o, 32'h8000_0000);
    chk("str_imm", if0.imm_o, 32'd5);
    chk("str_rd", 32'(if0.rd_addr_o), 32'd1);
    chk("str_we", 32'(if0.we_rd_o), 32'd1);
    cycle();
    if0.fetch_valid_i = 0;
    chk("str_pc1", if0.id_pc_o, 32'h8000_0004);
    cycle();
    chk("str_pc2", if0.id_pc_o, 32'h8000_0008);
    cycle();
    chk("str_end", 32'(if0.id_valid_o), 32'd0);

    // back-pressure: 6 beats, 5 fit
    if0.id_ready_i = 0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if0.fetch_valid_i = 1;
      if0.fetch_instr_i = 32'h0000_0093 | (32'(acc) << 20);
      will = if0.fetch_ready_o;
      cycle();
      if (will) acc++;
    end
    chk("bp_acc5", 32'(acc), 32'd5);
    chk("bp_full", 32'(if0.fetch_ready_o), 32'd0);
    chk("bp_hold", if0.imm_o, 32'd0);
    if0.id_ready_i = 1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      if (if0.id_valid_o) begin
        chk("bp_order", if0.imm_o, 32'(seen));
        seen++;
      end
      if0.fetch_valid_i = (acc < 6);
      if0.fetch_instr_i = 32'h0000_0093 | (32'(acc) << 20);
      will = if0.fetch_valid_i && if0.fetch_ready_o;
      cycle();
      if (will) acc++;
    end
    chk("bp_drain", 32'(seen), 32'd6);
    chk("bp_acc6", 32'(acc), 32'd6);
    if0.fetch_valid_i = 0;

    // illegal opcode locks the queue until redirect
    redirect(32'h100);
    if0.fetch_valid_i = 1; if0.fetch_instr_i = 32'hFFFF_FFFF;
    cycle();
    if0.fetch_instr_i = ADDI5;
    cycle();
    chk("trap_v", 32'(if0.id_valid_o), 32'd1);
    chk("trap_o", 32'(if0.trap_o), 32'd1);
    chk("trap_cause", 32'(if0.trap_cause_o), 32'd2);
    chk("trap_pc", if0.id_pc_o, 32'h100);
    chk("trap_we", 32'(if0.we_rd_o), 32'd0);
    cycle();
    if0.fetch_valid_i = 0;
    chk("trap_once", 32'(if0.id_valid_o), 32'd0);
    cycle(); cycle(); cycle();
    chk("trap_locked", 32'(if0.id_valid_o), 32'd0);
    redirect(32'h200);
    chk("jmp_clr", 32'(if0.id_valid_o), 32'd0);
    if0.fetch_valid_i = 1; if0.fetch_instr_i = ADDI5;
    cycle();
    if0.fetch_valid_i = 0;
    cycle();
    chk("jmp_v", 32'(if0.id_valid_o), 32'd1);
    chk("jmp_pc", if0.id_pc_o, 32'h200);
    chk("jmp_trap", 32'(if0.trap_o), 32'd0);
    cycle();

    // ECALL without system support is a NOP
    if1.fetch_valid_i = 1; if1.fetch_instr_i = 32'h0000_0073;
    cycle();
    if1.fetch_valid_i = 0;
    cycle();
    chk("nosys_v", 32'(if1.id_valid_o), 32'd1);
    chk("nosys_trap", 32'(if1.trap_o), 32'd0);
    chk("nosys_cause", 32'(if1.trap_cause_o), 32'd0);
    chk("nosys_we", 32'(if1.we_rd_o), 32'd0);
    cycle();

    // redirect drops a concurrent beat and a pending bundle
    if0.id_ready_i = 0;
    if0.fetch_valid_i = 1; if0.fetch_instr_i = ADDI5;
    cycle(); cycle();
    chk("jf_pend", 32'(if0.id_valid_o), 32'd1);
    jump_i = 1; pc_jump_i = 32'h300;
    cycle();
    jump_i = 0;
    chk("jf_v", 32'(if0.id_valid_o), 32'd0);
    chk("jf_rdy", 32'(if0.fetch_ready_o), 32'd1);
    if0.fetch_valid_i = 0; if0.id_ready_i = 1;
    cycle();
    chk("jf_empty", 32'(if0.id_valid_o), 32'd0);
    if0.fetch_valid_i = 1;
    cycle();
    if0.fetch_valid_i = 0;
    cycle();
    chk("jf_pc", if0.id_pc_o, 32'h300);
    cycle();

    // PC wraps past the top of the address space
    redirect(32'hFFFF_FFFC);
    if0.fetch_valid_i = 1;
    cycle(); cycle();
    if0.fetch_valid_i = 0;
    chk("wrap_pc0", if0.id_pc_o, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc1", if0.id_pc_o, 32'h0);
    cycle();

    // decode vector table
    for (int i = 0; i < NV; i++) begin
      redirect(32'h1000 + 32'(i) * 16);
      if0.fetch_valid_i = 1; if0.fetch_instr_i = vt[i].ins;
      cycle();
      if0.fetch_valid_i = 0;
      cycle();
      chk("vec_valid", 32'(if0.id_valid_o), 32'd1);
      chk("vec_pc", if0.id_pc_o, 32'h1000 + 32'(i) * 16);
      chk("vec_imm", if0.imm_o, vt[i].imm);
      chk("vec_rd", 32'(if0.rd_addr_o), 32'(vt[i].rd));
      chk("vec_f7", 32'(if0.f7_o), 32'(vt[i].f7));
      chk("vec_we", 32'(if0.we_rd_o), 32'(vt[i].we));
      chk("vec_lsu", 32'(if0.lsu_o), 32'(vt[i].lsu));
      chk("vec_br", 32'(if0.branch_o), 32'(vt[i].br));
      chk("vec_jmp", 32'(if0.jump_o), 32'(vt[i].jmp));
      chk("vec_s1", 32'(if0.rs1_sel_o), 32'(vt[i].s1));
      chk("vec_s2", 32'(if0.rs2_sel_o), 32'(vt[i].s2));
      chk("vec_trap", 32'(if0.trap_o), 32'(vt[i].trap));
      chk("vec_cause", 32'(if0.trap_cause_o), 32'(vt[i].cause));
    end

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      pc_reset_i = $urandom & 32'hFFFF_FFFC;
      jump_i = ($urandom_range(0, 14) == 0);
      pc_jump_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                : ($urandom & 32'hFFFF_FFFC);
      if0.fetch_valid_i = ($urandom_range(0, 3) != 0);
      if0.id_ready_i = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)
        if0.fetch_instr_i = vt[$urandom_range(0, NV - 1)].ins;
      else if (r == 7)
        if0.fetch_instr_i = $urandom;
      else if (r == 8)
        if0.fetch_instr_i = ($urandom & 32'hFFFF_FF80) | 32'h13;
      else
        if0.fetch_instr_i = ($urandom & 32'hFFFF_FF80)
                          | 32'(vt[$urandom_range(0, NV - 1)].ins[6:0]);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
